// File: rtl/soc1_ram_arb_pkg.sv
// soc1_ram_arb_pkg: shared widths, master IDs and RAM timing for the on-chip RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package soc1_ram_arb_pkg;
   localparam int ADDR_W         = 15;        // word address into the 25000-word RAM
   localparam int DATA_W         = 32;
   localparam int BE_W           = DATA_W / 8;
   localparam int RAM_RD_LATENCY = 1;         // RAM q valid one cycle after an accepted read

   typedef enum logic {
      M0 = 1'b0,                              // Nios CPU data master
      M1 = 1'b1                               // game-board / display scanner
   } mst_e;
endpackage

// File: rtl/soc1_ram_arbiter_if.sv
// soc1_ram_arbiter_if: both Avalon-MM master ports plus the RAM port of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: mN_waitrequest carried here; slave = arbiter side, master = masters/RAM side.
interface soc1_ram_arbiter_if;
   import soc1_ram_arb_pkg::*;

   logic [ADDR_W-1:0] m0_address;
   logic [BE_W-1:0]   m0_byteenable;
   logic              m0_read;
   logic              m0_write;
   logic [DATA_W-1:0] m0_writedata;
   logic              m0_waitrequest;
   logic [DATA_W-1:0] m0_readdata;
   logic              m0_readdatavalid;

   logic [ADDR_W-1:0] m1_address;
   logic [BE_W-1:0]   m1_byteenable;
   logic              m1_read;
   logic              m1_write;
   logic [DATA_W-1:0] m1_writedata;
   logic              m1_waitrequest;
   logic [DATA_W-1:0] m1_readdata;
   logic              m1_readdatavalid;

   logic [ADDR_W-1:0] ram_address;
   logic [BE_W-1:0]   ram_byteenable;
   logic              ram_chipselect;
   logic              ram_write;
   logic [DATA_W-1:0] ram_writedata;
   logic              ram_clken;
   logic [DATA_W-1:0] ram_readdata;

   modport slave (
      input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      output m1_waitrequest, m1_readdata, m1_readdatavalid,
      output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
      input  ram_readdata
   );

   modport master (
      output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid,
      input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
      output ram_readdata
   );
endinterface

// File: rtl/soc1_ram_arb_rr.sv
// soc1_ram_arb_rr: two-way round-robin grant with a bounded hold count (last_grant/hold_cnt).
// Latency: grant is combinational from req and registered state; state updates on accept.
// Backpressure: exactly one grant when any request; the other requester waits.
// Ports: clk/reset, req0_i/req1_i (requests), gnt0_o/gnt1_o (grants).
module soc1_ram_arb_rr
   import soc1_ram_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic req0_i,
   input  logic req1_i,
   output logic gnt0_o,
   output logic gnt1_o
);
   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

   mst_e       last_grant_q, last_grant_d, win;
   logic [3:0] hold_cnt_q, hold_cnt_d;
   logic       any_req, other_req;

   always_comb begin
      any_req = req0_i | req1_i;
      win     = req0_i ? M0 : M1;
      if (req0_i && req1_i) begin
         // hold_cnt of zero only exists straight out of reset: nobody holds the
         // grant yet, so the master opposite last_grant (m0) wins the first contention.
         if (hold_cnt_q != 4'd0 && hold_cnt_q < HOLD_MAX)
            win = last_grant_q;
         else
            win = (last_grant_q == M0) ? M1 : M0;
      end
      other_req = (win == M0) ? req1_i : req0_i;
      gnt0_o    = any_req && (win == M0);
      gnt1_o    = any_req && (win == M1);

      last_grant_d = last_grant_q;
      hold_cnt_d   = hold_cnt_q;
      if (any_req) begin
         if (win != last_grant_q) begin
            last_grant_d = win;
            hold_cnt_d   = 4'd1;
         end else if (other_req && hold_cnt_q < HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
         end
         // Same master with the other idle: count untouched, no forced yield.
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= M1;
         hold_cnt_q   <= 4'd0;
      end else begin
         last_grant_q <= last_grant_d;
         hold_cnt_q   <= hold_cnt_d;
      end
   end
endmodule

// File: rtl/soc1_ram_arbiter.sv
// soc1_ram_arbiter: shares the single-port 32-bit on-chip RAM between CPU (m0) and scanner (m1).
// Latency: winner's command reaches the RAM in the accept cycle; readdata at master 2 cycles later.
// Backpressure: mN_waitrequest high until that master wins; one accept per cycle, no buffering.
// Ports: clk, reset (async active-high), bus (slave modport: m0_*, m1_*, ram_*).
// Optional macro SOC1_RAM_ARB_STATS_EN adds stat_clear, stat_m0_acc, stat_m1_acc, stat_conflict.
module soc1_ram_arbiter
   import soc1_ram_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
   soc1_ram_arbiter_if.slave bus
`ifdef SOC1_RAM_ARB_STATS_EN
   ,
   input  logic              stat_clear,
   output logic [31:0]       stat_m0_acc,
   output logic [31:0]       stat_m1_acc,
   output logic [31:0]       stat_conflict
`endif
);
   logic req0, req1, gnt0, gnt1, sel_wr, cs, rd_acc;
   mst_e win;

   logic              rd_pending_q, rd_pending_d;
   mst_e              rd_owner_q, rd_owner_d;
   logic              m0_rvld_q, m0_rvld_d, m1_rvld_q, m1_rvld_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

   // Requests are masked during reset so no command is accepted and waitrequest stays high.
   assign req0 = ~reset & (bus.m0_read | bus.m0_write);
   assign req1 = ~reset & (bus.m1_read | bus.m1_write);

   soc1_ram_arb_rr #(.MAX_HOLD(MAX_HOLD)) u_rr (
      .clk    (clk),
      .reset  (reset),
      .req0_i (req0),
      .req1_i (req1),
      .gnt0_o (gnt0),
      .gnt1_o (gnt1)
   );

   // Read+write together is treated as a write: sel_wr wins over read.
   assign win    = gnt1 ? M1 : M0;
   assign cs     = gnt0 | gnt1;
   assign sel_wr = (win == M1) ? bus.m1_write : bus.m0_write;
   assign rd_acc = cs & ~sel_wr;

   assign bus.ram_address    = (win == M1) ? bus.m1_address    : bus.m0_address;
   assign bus.ram_byteenable = (win == M1) ? bus.m1_byteenable : bus.m0_byteenable;
   assign bus.ram_writedata  = (win == M1) ? bus.m1_writedata  : bus.m0_writedata;
   assign bus.ram_chipselect = cs;
   assign bus.ram_write      = cs & sel_wr;
   assign bus.ram_clken      = ~reset;

   assign bus.m0_waitrequest   = ~gnt0;
   assign bus.m1_waitrequest   = ~gnt1;
   assign bus.m0_readdata      = m0_rdata_q;
   assign bus.m1_readdata      = m1_rdata_q;
   assign bus.m0_readdatavalid = m0_rvld_q;
   assign bus.m1_readdatavalid = m1_rvld_q;

   // Response pipeline sized for RAM_RD_LATENCY: the RAM q is valid while rd_pending_q
   // is set, gets captured into the owner's readdata register, and valid pulses next cycle.
   // Fixed latency keeps responses in accept order without tags.
   always_comb begin
      rd_pending_d = rd_acc;
      rd_owner_d   = win;
      m0_rvld_d    = rd_pending_q && (rd_owner_q == M0);
      m1_rvld_d    = rd_pending_q && (rd_owner_q == M1);
      m0_rdata_d   = m0_rvld_d ? bus.ram_readdata : m0_rdata_q;
      m1_rdata_d   = m1_rvld_d ? bus.ram_readdata : m1_rdata_q;
   end

   // Reset drops any in-flight response; masters must reissue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pending_q <= 1'b0;
         rd_owner_q   <= M0;
         m0_rvld_q    <= 1'b0;
         m1_rvld_q    <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         rd_pending_q <= rd_pending_d;
         rd_owner_q   <= rd_owner_d;
         m0_rvld_q    <= m0_rvld_d;
         m1_rvld_q    <= m1_rvld_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
      end
   end

   a_m0_rd_wr: assert property (@(posedge clk) disable iff (reset) !(bus.m0_read && bus.m0_write));
   a_m1_rd_wr: assert property (@(posedge clk) disable iff (reset) !(bus.m1_read && bus.m1_write));

`ifdef SOC1_RAM_ARB_STATS_EN
   logic [31:0] m0_acc_q, m0_acc_d, m1_acc_q, m1_acc_d, conflict_q, conflict_d;

   always_comb begin
      m0_acc_d   = m0_acc_q   + {31'd0, gnt0};
      m1_acc_d   = m1_acc_q   + {31'd0, gnt1};
      conflict_d = conflict_q + {31'd0, req0 & req1};
      if (stat_clear) begin
         m0_acc_d   = '0;
         m1_acc_d   = '0;
         conflict_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m0_acc_q   <= '0;
         m1_acc_q   <= '0;
         conflict_q <= '0;
      end else begin
         m0_acc_q   <= m0_acc_d;
         m1_acc_q   <= m1_acc_d;
         conflict_q <= conflict_d;
      end
   end

   assign stat_m0_acc   = m0_acc_q;
   assign stat_m1_acc   = m1_acc_q;
   assign stat_conflict = conflict_q;
`endif
endmodule

// File: tb/tb_soc1_ram_arbiter.sv
// tb_soc1_ram_arbiter: directed bench for soc1_ram_arbiter with a small behavioural RAM.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_soc1_ram_arbiter;
   import soc1_ram_arb_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   soc1_ram_arbiter_if bus();

`ifdef SOC1_RAM_ARB_STATS_EN
   logic        stat_clear = 1'b0;
   logic [31:0] stat_m0_acc, stat_m1_acc, stat_conflict;
`endif

   soc1_ram_arbiter #(.MAX_HOLD(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef SOC1_RAM_ARB_STATS_EN
      ,
      .stat_clear    (stat_clear),
      .stat_m0_acc   (stat_m0_acc),
      .stat_m1_acc   (stat_m1_acc),
      .stat_conflict (stat_conflict)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural RAM: never-written words read back a fixed address pattern.
   bit [31:0]   mem [0:1023];
   bit [1023:0] wr_vld;

   function automatic logic [31:0] pat(input logic [14:0] a);
      return 32'h5A00_0000 | {17'd0, a};
   endfunction

   always @(posedge clk) begin
      if (bus.ram_clken && bus.ram_chipselect) begin
         if (bus.ram_write) begin
            for (int b = 0; b < 4; b++)
               if (bus.ram_byteenable[b])
                  mem[bus.ram_address[9:0]][8*b +: 8] <= bus.ram_writedata[8*b +: 8];
            wr_vld[bus.ram_address[9:0]] <= 1'b1;
         end else begin
            bus.ram_readdata <= wr_vld[bus.ram_address[9:0]] ? mem[bus.ram_address[9:0]]
                                                             : pat(bus.ram_address);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus.m0_read = 1'b0; bus.m0_write = 1'b0;
      bus.m1_read = 1'b0; bus.m1_write = 1'b0;
   endtask

   task automatic m0_cmd(input logic rd, input logic wr, input logic [14:0] a,
                         input logic [3:0] be, input logic [31:0] d);
      bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a;
      bus.m0_byteenable = be; bus.m0_writedata = d;
   endtask

   task automatic m1_cmd(input logic rd, input logic wr, input logic [14:0] a,
                         input logic [3:0] be, input logic [31:0] d);
      bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a;
      bus.m1_byteenable = be; bus.m1_writedata = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   logic        own [0:15];
   logic [31:0] dat [0:15];

   initial begin
      int   n_acc, n_rv, n0, n1;
      logic g1;
      idle_all();
      m0_cmd(0, 0, 15'd0, 4'h0, 32'd0);
      m1_cmd(0, 0, 15'd0, 4'h0, 32'd0);
      cyc(); cyc();

      // Reset state, with an m0 write already presented.
      m0_cmd(0, 1, 15'h0010, 4'hF, 32'hDEADBEEF);
      #1;
      chk("rst_m0_wait", bus.m0_waitrequest, 1);
      chk("rst_m1_wait", bus.m1_waitrequest, 1);
      chk("rst_cs", bus.ram_chipselect, 0);
      chk("rst_ram_write", bus.ram_write, 0);
      chk("rst_clken", bus.ram_clken, 0);
      chk("rst_m0_rvld", bus.m0_readdatavalid, 0);
      chk("rst_m1_rvld", bus.m1_readdatavalid, 0);
      chk("rst_m0_rdata", bus.m0_readdata, 0);
      chk("rst_m1_rdata", bus.m1_readdata, 0);

      // First cycle after release: m0 write accepted.
      reset = 1'b0;
      #1;
      chk("wr_m0_wait", bus.m0_waitrequest, 0);
      chk("wr_m1_wait", bus.m1_waitrequest, 1);
      chk("wr_cs", bus.ram_chipselect, 1);
      chk("wr_ram_write", bus.ram_write, 1);
      chk("wr_clken", bus.ram_clken, 1);
      chk("wr_addr", bus.ram_address, 32'h10);
      chk("wr_data", bus.ram_writedata, 32'hDEADBEEF);
      cyc();

      // Read back: valid exactly 2 cycles after accept, on m0 only.
      m0_cmd(1, 0, 15'h0010, 4'hF, 32'd0);
      #1;
      chk("rd_m0_wait", bus.m0_waitrequest, 0);
      chk("rd_ram_write", bus.ram_write, 0);
      cyc();
      idle_all();
      chk("rd_rvld_early", bus.m0_readdatavalid, 0);
      cyc();
      chk("rd_rvld", bus.m0_readdatavalid, 1);
      chk("rd_data", bus.m0_readdata, 32'hDEADBEEF);
      chk("rd_m1_rvld", bus.m1_readdatavalid, 0);
      cyc();
      chk("rd_rvld_pulse", bus.m0_readdatavalid, 0);

      // Byte-enable merge.
      m0_cmd(0, 1, 15'h0020, 4'hF, 32'h11223344);
      cyc();
      m0_cmd(0, 1, 15'h0020, 4'h2, 32'h0000AB00);
      #1;
      chk("be_m0_wait", bus.m0_waitrequest, 0);
      cyc();
      m0_cmd(1, 0, 15'h0020, 4'hF, 32'd0);
      cyc();
      idle_all();
      cyc();
      chk("be_rvld", bus.m0_readdatavalid, 1);
      chk("be_data", bus.m0_readdata, 32'h1122AB44);

      // 20 back-to-back m0 reads with m1 idle.
      n_acc = 0;
      n_rv  = 0;
      for (int i = 0; i < 22; i++) begin
         if (i < 20) m0_cmd(1, 0, 15'(32'h100 + i), 4'hF, 32'd0);
         else idle_all();
         #1;
         if (i < 20 && bus.m0_waitrequest == 1'b0) n_acc++;
         if (bus.m1_readdatavalid) n_rv++;
         if (i >= 2) begin
            chk("burst_rvld", bus.m0_readdatavalid, 1);
            chk("burst_data", bus.m0_readdata, pat(15'(32'h100 + i - 2)));
         end
         cyc();
      end
      chk("burst_accepts", n_acc, 20);
      chk("burst_m1_rvld", n_rv, 0);

      // hold_cnt stayed at 1 during the solo burst: m0 keeps 3 more, then m1.
      for (int i = 0; i < 4; i++) begin
         m0_cmd(1, 0, 15'h0100, 4'hF, 32'd0);
         m1_cmd(1, 0, 15'h0200, 4'hF, 32'd0);
         #1;
         chk("post_m0_wait", bus.m0_waitrequest, (i == 3));
         chk("post_m1_wait", bus.m1_waitrequest, (i < 3));
         cyc();
      end
      idle_all();

      // Fresh reset, then continuous dual reads: 4 m0, 4 m1, alternating.
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      n0 = 0;
      n1 = 0;
      for (int c = 0; c < 18; c++) begin
         if (c < 16) begin
            m0_cmd(1, 0, 15'(32'h100 + n0), 4'hF, 32'd0);
            m1_cmd(1, 0, 15'(32'h200 + n1), 4'hF, 32'd0);
         end else begin
            idle_all();
         end
         #1;
         g1 = ((c / 4) % 2) == 1;
         if (c < 16) begin
            chk("rr_m0_wait", bus.m0_waitrequest, g1);
            chk("rr_m1_wait", bus.m1_waitrequest, !g1);
            own[c] = g1;
            dat[c] = g1 ? pat(15'(32'h200 + n1)) : pat(15'(32'h100 + n0));
            if (g1) n1++;
            else n0++;
         end
         if (c >= 2) begin
            chk("rr_m0_rvld", bus.m0_readdatavalid, !own[c-2]);
            chk("rr_m1_rvld", bus.m1_readdatavalid, own[c-2]);
            chk("rr_data", own[c-2] ? bus.m1_readdata : bus.m0_readdata, dat[c-2]);
         end
         cyc();
      end

      // Reset one cycle after an accepted m1 read: response is dropped.
      m1_cmd(1, 0, 15'h0205, 4'hF, 32'd0);
      #1;
      chk("mid_m1_wait", bus.m1_waitrequest, 0);
      cyc();
      idle_all();
      reset = 1'b1;
      m0_cmd(0, 1, 15'h0030, 4'hF, 32'h12345678);
      #1;
      chk("mid_rst_m0_wait", bus.m0_waitrequest, 1);
      chk("mid_rst_m1_wait", bus.m1_waitrequest, 1);
      chk("mid_rst_cs", bus.ram_chipselect, 0);
      chk("mid_rst_clken", bus.ram_clken, 0);
      cyc(); cyc();
      idle_all();
      reset = 1'b0;
      n_rv = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (bus.m1_readdatavalid) n_rv++;
         cyc();
      end
      chk("mid_m1_rvld_count", n_rv, 0);
      chk("mid_m1_rdata", bus.m1_readdata, 0);

`ifdef SOC1_RAM_ARB_STATS_EN
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         m0_cmd(1, 0, 15'h0100, 4'hF, 32'd0);
         m1_cmd(1, 0, 15'h0200, 4'hF, 32'd0);
         cyc();
      end
      idle_all();
      #1;
      chk("stat_conflict", stat_conflict, 10);
      chk("stat_acc_sum", stat_m0_acc + stat_m1_acc, 10);
      stat_clear = 1'b1;
      cyc();
      stat_clear = 1'b0;
      #1;
      chk("stat_clr_m0", stat_m0_acc, 0);
      chk("stat_clr_m1", stat_m1_acc, 0);
      chk("stat_clr_conf", stat_conflict, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/soc1_ram_arbiter.md
Name: soc1_ram_arbiter

Overview:
- Two-master arbiter that shares the single-port 32-bit on-chip RAM (25000 words, 15-bit word address, byte enables, 1-cycle read latency) between the Nios CPU data master (m0) and the game-board/display scanner (m1).
- Presents an Avalon-MM slave with waitrequest and readdatavalid to each master, and drives the RAM's chipselect/write/clken port.
- Round-robin arbitration with a bounded hold count gives the scanner guaranteed bandwidth while the CPU keeps burst locality.

Parameters:
- ADDR_W, 15, word-address width to the RAM
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- MAX_HOLD, 4, max consecutive accepted commands for one master while the other is requesting (1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- m0_address  in  ADDR_W  CPU word address
- m0_byteenable  in  BE_W  CPU byte enables
- m0_read  in  1  CPU read request
- m0_write  in  1  CPU write request
- m0_writedata  in  DATA_W  CPU write data
- m0_waitrequest  out  1  high = command not accepted this cycle
- m0_readdata  out  DATA_W  read data to CPU
- m0_readdatavalid  out  1  one-cycle pulse, m0_readdata valid
- m1_address / m1_byteenable / m1_read / m1_write / m1_writedata  in  as m0  scanner command
- m1_waitrequest / m1_readdata / m1_readdatavalid  out  as m0  scanner response
- ram_address  out  ADDR_W  to RAM address
- ram_byteenable  out  BE_W  to RAM byteenable
- ram_chipselect  out  1  high only in cycles with an accepted command
- ram_write  out  1  accepted command is a write
- ram_writedata  out  DATA_W  to RAM writedata
- ram_clken  out  1  tied high outside reset
- ram_readdata  in  DATA_W  RAM q, valid 1 cycle after an accepted read

Behaviour:
- Reset (async assert, sync deassert by system): waitrequest both 1, readdatavalid both 0, readdata both 0, ram_chipselect/ram_write 0, ram_clken 0, last_grant=m1 (so m0 wins first contention), hold_cnt=0, rd_pending=0.
- reqN = mN_read | mN_write. A master asserting read and write together is illegal; treat it as a write. Simulation assertion flags it.
- Grant (combinational from registered state): if only one master requests, it wins. If both request: the master != last_grant wins, unless last_grant's hold_cnt < MAX_HOLD, in which case last_grant keeps the grant.
- Accepted cycle: the winner's waitrequest=0 and its command passes combinationally to ram_* with ram_chipselect=1; the loser's waitrequest=1. With no request, both waitrequest=1 and chipselect=0.
- Throughput: one command per cycle; back-to-back accepts allowed.
- hold_cnt update on accept:
  - same master as last_grant and other master requesting: hold_cnt+1, saturating at MAX_HOLD
  - different master: last_grant updates, hold_cnt=1
  - other master idle: hold_cnt unchanged (no forced yield)
- Read response: an accepted read sets rd_pending=1 and rd_owner=winner. Next cycle: owner's readdata is registered from ram_readdata and readdatavalid pulses 1 cycle later. Read latency at master is therefore 2 cycles from accept. Responses stay strictly in order because latency is fixed.
- Writes generate no response. A read from one master followed by a write from the other on the next cycle is legal; the RAM is pipelined.
- Reset mid-operation: pending read responses are discarded and no readdatavalid is issued after reset. Masters must reissue.
- Addresses ≥25000 are passed through unchecked.

Optional Feature:
- SOC1_RAM_ARB_STATS_EN defined: adds outputs stat_m0_acc[31:0], stat_m1_acc[31:0] (accepted-command counters) and stat_conflict[31:0] (cycles where both masters requested). All wrap at 2^32, clear on reset, and also clear on the one-cycle input stat_clear.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package soc1_ram_arb_pkg holds: ADDR_W/DATA_W/BE_W defaults, master-ID constants M0=0 and M1=1, RAM_RD_LATENCY=1.
- One sub-module, soc1_ram_arb_rr: grant logic plus last_grant/hold_cnt registers. The top handles muxing and the response pipeline.

Test Plan:
- Reset release with m0 write addr 0x0010 data 0xDEADBEEF be 0xF -> accepted in cycle 1, ram_chipselect=1, ram_write=1. m0 read of 0x0010 -> m0_readdatavalid 2 cycles after accept with 0xDEADBEEF. m1_readdatavalid stays 0.
- Both masters read continuously, MAX_HOLD=4 -> m0 gets 4 accepts, then m1 gets 4, alternating. Each readdatavalid routes to the correct master in order.
- m1 idle, m0 issues 20 back-to-back reads -> 20 accepts in 20 cycles, no forced yield, hold_cnt unchanged.
- Byte write be=0x2 data 0x0000AB00 to a word holding 0x11223344 -> readback 0x1122AB44.
- Assert reset one cycle after an accepted m1 read -> no m1_readdatavalid ever appears. waitrequest=1 and chipselect=0 while reset is asserted.
- With SOC1_RAM_ARB_STATS_EN: 10 cycles of dual requests -> stat_conflict=10 and stat_m0_acc+stat_m1_acc=10. stat_clear -> all counters 0.
